// File: rtl/nand_cpu_pkg.sv
// Shared types for the store issue path: FSM state encoding and the latched store-buffer head entry.
// ROB_LENGTH / NUM_D_REG normally come from nand_cpu.svh; defaults below cover standalone builds.
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 16
`endif

package nand_cpu_pkg;

   localparam int RW = $clog2(`ROB_LENGTH);
   localparam int DW = $clog2(`NUM_D_REG);

   typedef enum logic [1:0] {
      SIS_IDLE,
      SIS_READ,
      SIS_MEM,
      SIS_DONE
   } sis_state_e;

   typedef struct packed {
      logic [RW-1:0] rob_addr;
      logic [DW-1:0] ra_addr;
      logic [DW-1:0] rt_addr;
   } store_req_t;

endpackage

// File: rtl/store_issue_unit_if.sv
// Bundles the store-buffer, register-file, data-memory and ROB-completion signals of the store issue unit.
// master = store issue unit side, slave = surrounding pipeline/memory side.
interface store_issue_unit_if
   import nand_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);

   logic              sb_valid;
   logic [RW-1:0]     sb_rob_addr;
   logic [DW-1:0]     sb_ra_addr;
   logic [DW-1:0]     sb_rt_addr;
   logic              sb_pop;

   logic [DW-1:0]     rf_ra_addr;
   logic [DW-1:0]     rf_rt_addr;
   logic [DATA_W-1:0] rf_ra_data;
   logic [DATA_W-1:0] rf_rt_data;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;

   logic              rob_done_valid;
   logic [RW-1:0]     rob_done_addr;

   modport master (
      input  sb_valid, sb_rob_addr, sb_ra_addr, sb_rt_addr,
      output sb_pop,
      output rf_ra_addr, rf_rt_addr,
      input  rf_ra_data, rf_rt_data,
      output mem_req, mem_addr, mem_wdata,
      input  mem_ack,
      output rob_done_valid, rob_done_addr
   );

   modport slave (
      output sb_valid, sb_rob_addr, sb_ra_addr, sb_rt_addr,
      input  sb_pop,
      input  rf_ra_addr, rf_rt_addr,
      output rf_ra_data, rf_rt_data,
      input  mem_req, mem_addr, mem_wdata,
      output mem_ack,
      input  rob_done_valid, rob_done_addr
   );

endinterface

// File: rtl/store_issue_perf.sv
// Two saturating 16-bit event counters: completed stores and memory-stall cycles.
module store_issue_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_incStores,
   input  logic        i_incStall,
   output logic [15:0] o_stores,
   output logic [15:0] o_stall
);

   logic [15:0] r_stores;
   logic [15:0] r_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stores <= 16'd0;
         r_stall  <= 16'd0;
      end else begin
         if (i_incStores && (r_stores != 16'hFFFF))
            r_stores <= r_stores + 16'd1;
         if (i_incStall && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;
      end
   end

   assign o_stores = r_stores;
   assign o_stall  = r_stall;

endmodule

// File: rtl/store_issue_unit.sv
// Pops the in-order store buffer head, reads base/data regs, issues one memory write, then signals the ROB.
// Optional STORE_ISSUE_PERF_EN adds saturating perf_stores / perf_stall counters.
module store_issue_unit
   import nand_cpu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
)(
   input  logic               clk,
   input  logic               rst,
   store_issue_unit_if.master bus,
   input  logic               flush,
   output logic               busy
`ifdef STORE_ISSUE_PERF_EN
   ,
   output logic [15:0]        perf_stores,
   output logic [15:0]        perf_stall
`endif
);

   sis_state_e        r_state;
   sis_state_e        w_stateNext;
   store_req_t        r_req;
   logic [DATA_W-1:0] r_raData;
   logic [DATA_W-1:0] r_rtData;
   logic              r_memReq;
   logic              w_memReqNext;
   logic              w_pop;
   logic              w_capture;
   logic [ADDR_W-1:0] w_memAddr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= SIS_IDLE;
         r_req    <= '0;
         r_raData <= '0;
         r_rtData <= '0;
         r_memReq <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_memReq <= w_memReqNext;
         if (w_pop)
            r_req <= '{rob_addr: bus.sb_rob_addr, ra_addr: bus.sb_ra_addr, rt_addr: bus.sb_rt_addr};
         if (w_capture) begin
            r_raData <= bus.rf_ra_data;
            r_rtData <= bus.rf_rt_data;
         end
      end
   end

   // Once the request is raised the write is committed, so flush only matters in IDLE and READ.
   always_comb begin
      w_stateNext  = r_state;
      w_memReqNext = r_memReq;
      w_pop        = 1'b0;
      w_capture    = 1'b0;
      unique case (r_state)
         SIS_IDLE: begin
            if (bus.sb_valid && !flush && !rst) begin
               w_pop       = 1'b1;
               w_stateNext = SIS_READ;
            end
         end
         SIS_READ: begin
            if (flush) begin
               w_stateNext = SIS_IDLE;
            end else begin
               w_capture    = 1'b1;
               w_memReqNext = 1'b1;
               w_stateNext  = SIS_MEM;
            end
         end
         SIS_MEM: begin
            if (bus.mem_ack) begin
               w_memReqNext = 1'b0;
               w_stateNext  = SIS_DONE;
            end
         end
         SIS_DONE: begin
            w_stateNext = SIS_IDLE;
         end
         default: begin
            w_memReqNext = 1'b0;
            w_stateNext  = SIS_IDLE;
         end
      endcase
   end

   generate
      if (ADDR_W > DATA_W) begin : gZeroExtend
         assign w_memAddr = {{(ADDR_W-DATA_W){1'b0}}, r_raData};
      end else begin : gTruncate
         assign w_memAddr = r_raData[ADDR_W-1:0];
      end
   endgenerate

   assign bus.sb_pop         = w_pop;
   assign bus.rf_ra_addr     = r_req.ra_addr;
   assign bus.rf_rt_addr     = r_req.rt_addr;
   assign bus.mem_req        = r_memReq;
   assign bus.mem_addr       = w_memAddr;
   assign bus.mem_wdata      = r_rtData;
   assign bus.rob_done_valid = (r_state == SIS_DONE);
   assign bus.rob_done_addr  = r_req.rob_addr;
   assign busy               = (r_state != SIS_IDLE);

`ifdef STORE_ISSUE_PERF_EN
   store_issue_perf uPerf (
      .clk         (clk),
      .rst         (rst),
      .i_incStores (r_state == SIS_DONE),
      .i_incStall  ((r_state == SIS_MEM) && !bus.mem_ack),
      .o_stores    (perf_stores),
      .o_stall     (perf_stall)
   );
`endif

endmodule

// File: tb/tb_store_issue_unit.sv
// Directed bench for store_issue_unit with a write/completion scoreboard; build with STORE_ISSUE_PERF_EN to also check counters.
module tb_store_issue_unit;
   import nand_cpu_pkg::*;

   typedef struct {
      logic [3:0] tag;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [3:0] rob;
      logic [3:0] ra;
      logic [3:0] rt;
   } sb_t;

   logic clk;
   logic rst;
   logic flush;
   logic busy;
`ifdef STORE_ISSUE_PERF_EN
   logic [15:0] perf_stores;
   logic [15:0] perf_stall;
`endif

   int   compared   = 0;
   int   mismatched = 0;
   int   doneCount  = 0;
   int   doneBase;
   exp_t sbExp[$];
   sb_t  sbq[$];
   logic [7:0] rfMem [16];

   store_issue_unit_if #(.DATA_W(8), .ADDR_W(8)) bus ();

   store_issue_unit #(.DATA_W(8), .ADDR_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.master),
      .flush (flush),
      .busy  (busy)
`ifdef STORE_ISSUE_PERF_EN
      ,
      .perf_stores (perf_stores),
      .perf_stall  (perf_stall)
`endif
   );

   assign bus.rf_ra_data = rfMem[bus.rf_ra_addr];
   assign bus.rf_rt_data = rfMem[bus.rf_rt_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] rob, input logic [3:0] ra,
                                input logic [3:0] rt, input logic fl, input logic ack);
      bus.sb_valid    = v;
      bus.sb_rob_addr = rob;
      bus.sb_ra_addr  = ra;
      bus.sb_rt_addr  = rt;
      flush           = fl;
      bus.mem_ack     = ack;
   endtask

   task automatic pushExp(input logic [3:0] tag, input logic [3:0] ra, input logic [3:0] rt);
      exp_t e;
      e.tag  = tag;
      e.addr = rfMem[ra];
      e.data = rfMem[rt];
      sbExp.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Scoreboard: every accepted write and every completion must match the oldest expected store.
   always @(negedge clk) begin
      if (bus.mem_req && bus.mem_ack) begin
         checkOutput("writeExpected", 32'(sbExp.size() > 0), 1);
         if (sbExp.size() > 0) begin
            checkOutput("sbMemAddr", bus.mem_addr, sbExp[0].addr);
            checkOutput("sbMemData", bus.mem_wdata, sbExp[0].data);
         end
      end
      if (bus.rob_done_valid) begin
         doneCount++;
         checkOutput("doneExpected", 32'(sbExp.size() > 0), 1);
         if (sbExp.size() > 0) begin
            checkOutput("sbDoneTag", bus.rob_done_addr, sbExp[0].tag);
            void'(sbExp.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) rfMem[i] = 8'(i * 3);
      rfMem[3] = 8'h20; rfMem[4] = 8'hAB;
      rfMem[1] = 8'h40; rfMem[2] = 8'h5C;
      rfMem[5] = 8'h11; rfMem[6] = 8'h22;
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);

      // Reset state, with a valid head that must not be popped while in reset
      step; applyStimulus(1, 4'd2, 4'd3, 4'd4, 0, 0); settle;
      checkOutput("rstPop", bus.sb_pop, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstMemReq", bus.mem_req, 0);
      checkOutput("rstDone", bus.rob_done_valid, 0);
      checkOutput("rstDoneAddr", bus.rob_done_addr, 0);
      checkOutput("rstMemAddr", bus.mem_addr, 0);
      checkOutput("rstMemData", bus.mem_wdata, 0);
      step; rst = 1'b0; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("rstNoLatch", busy, 0);

      // Test 1: basic store, ack on first request cycle
      step; applyStimulus(1, 4'd5, 4'd3, 4'd4, 0, 0); settle;
      checkOutput("t1Pop", bus.sb_pop, 1);
      pushExp(4'd5, 4'd3, 4'd4);
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t1ReadPop", bus.sb_pop, 0);
      checkOutput("t1ReadBusy", busy, 1);
      checkOutput("t1ReadReq", bus.mem_req, 0);
      checkOutput("t1RfRa", bus.rf_ra_addr, 3);
      checkOutput("t1RfRt", bus.rf_rt_addr, 4);
      step; applyStimulus(0, 0, 0, 0, 0, 1); settle;
      checkOutput("t1MemReq", bus.mem_req, 1);
      checkOutput("t1MemAddr", bus.mem_addr, 8'h20);
      checkOutput("t1MemData", bus.mem_wdata, 8'hAB);
      checkOutput("t1NoEarlyDone", bus.rob_done_valid, 0);
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t1ReqDrop", bus.mem_req, 0);
      checkOutput("t1Done", bus.rob_done_valid, 1);
      checkOutput("t1DoneAddr", bus.rob_done_addr, 5);
      step; settle;
      checkOutput("t1Idle", busy, 0);
      checkOutput("t1DoneOnce", bus.rob_done_valid, 0);

      // Test 2: ack delayed 3 cycles; request must hold the captured values
      doneBase = doneCount;
      step; applyStimulus(1, 4'd6, 4'd1, 4'd2, 0, 0); settle;
      checkOutput("t2Pop", bus.sb_pop, 1);
      pushExp(4'd6, 4'd1, 4'd2);
      step; applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step; applyStimulus(0, 0, 0, 0, 0, (i == 3));
         if (i == 1) rfMem[1] = 8'h99;
         settle;
         checkOutput("t2MemReq", bus.mem_req, 1);
         checkOutput("t2MemAddr", bus.mem_addr, 8'h40);
         checkOutput("t2MemData", bus.mem_wdata, 8'h5C);
         checkOutput("t2NoDone", bus.rob_done_valid, 0);
      end
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t2Done", bus.rob_done_valid, 1);
      checkOutput("t2DoneAddr", bus.rob_done_addr, 6);
      checkOutput("t2ReqDrop", bus.mem_req, 0);
      step; settle;
      checkOutput("t2Idle", busy, 0);
      checkOutput("t2DoneOnce", doneCount - doneBase, 1);
`ifdef STORE_ISSUE_PERF_EN
      checkOutput("perfStores", perf_stores, 2);
      checkOutput("perfStall", perf_stall, 3);
`endif

      // Test 3a: flush with valid in IDLE, then flush in READ
      doneBase = doneCount;
      step; applyStimulus(1, 4'd7, 4'd3, 4'd4, 1, 0); settle;
      checkOutput("t3FlushNoPop", bus.sb_pop, 0);
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t3FlushStayIdle", busy, 0);
      step; applyStimulus(1, 4'd7, 4'd3, 4'd4, 0, 0); settle;
      checkOutput("t3Pop", bus.sb_pop, 1);
      step; applyStimulus(0, 0, 0, 0, 1, 0); settle;
      checkOutput("t3ReadBusy", busy, 1);
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t3FlushIdle", busy, 0);
      checkOutput("t3FlushNoReq", bus.mem_req, 0);
      step; settle;
      checkOutput("t3FlushNoReq2", bus.mem_req, 0);
      checkOutput("t3FlushNoDone", doneCount - doneBase, 0);

      // Test 3b: flush in MEM and DONE is ignored
      step; applyStimulus(1, 4'd8, 4'd5, 4'd6, 0, 0); settle;
      checkOutput("t3bPop", bus.sb_pop, 1);
      pushExp(4'd8, 4'd5, 4'd6);
      step; applyStimulus(0, 0, 0, 0, 0, 0);
      step; applyStimulus(0, 0, 0, 0, 1, 0); settle;
      checkOutput("t3bReqFlush", bus.mem_req, 1);
      step; applyStimulus(0, 0, 0, 0, 1, 1); settle;
      checkOutput("t3bReqHold", bus.mem_req, 1);
      checkOutput("t3bAddr", bus.mem_addr, 8'h11);
      step; applyStimulus(0, 0, 0, 0, 1, 0); settle;
      checkOutput("t3bDone", bus.rob_done_valid, 1);
      checkOutput("t3bDoneAddr", bus.rob_done_addr, 8);
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t3bIdle", busy, 0);

      // Test 4: back-to-back head entries; pops every 4 cycles
      doneBase = doneCount;
      rfMem[7] = 8'h70; rfMem[8] = 8'h81; rfMem[9] = 8'h92;
      rfMem[10] = 8'hA3; rfMem[11] = 8'hB4; rfMem[12] = 8'hC5;
      sbq.push_back('{4'd1, 4'd7, 4'd8});
      sbq.push_back('{4'd2, 4'd9, 4'd10});
      sbq.push_back('{4'd3, 4'd11, 4'd12});
      for (int c = 0; c < 14; c++) begin
         step;
         if (sbq.size() > 0)
            applyStimulus(1, sbq[0].rob, sbq[0].ra, sbq[0].rt, 0, bus.mem_req);
         else
            applyStimulus(0, 0, 0, 0, 0, bus.mem_req);
         settle;
         checkOutput("t4Pop", bus.sb_pop, 32'((c < 12) && (c % 4 == 0)));
         checkOutput("t4Busy", busy, 32'((c < 12) && (c % 4 != 0)));
         if (bus.sb_pop && sbq.size() > 0) begin
            pushExp(sbq[0].rob, sbq[0].ra, sbq[0].rt);
            void'(sbq.pop_front());
         end
      end
      checkOutput("t4DoneCount", doneCount - doneBase, 3);
      checkOutput("t4Drained", sbExp.size(), 0);

      // Test 5: reset while the request is outstanding
      doneBase = doneCount;
      step; applyStimulus(1, 4'd9, 4'd3, 4'd4, 0, 0); settle;
      checkOutput("t5Pop", bus.sb_pop, 1);
      step; applyStimulus(0, 0, 0, 0, 0, 0);
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t5MemReq", bus.mem_req, 1);
      rst = 1'b1;
      step; rst = 1'b0; applyStimulus(0, 0, 0, 0, 0, 1); settle;
      checkOutput("t5ReqDrop", bus.mem_req, 0);
      checkOutput("t5Busy", busy, 0);
      checkOutput("t5DoneAddr", bus.rob_done_addr, 0);
`ifdef STORE_ISSUE_PERF_EN
      checkOutput("perfStoresClr", perf_stores, 0);
      checkOutput("perfStallClr", perf_stall, 0);
`endif
      step; applyStimulus(0, 0, 0, 0, 0, 0); settle;
      checkOutput("t5StrayAck", bus.rob_done_valid, 0);
      checkOutput("t5StillIdle", busy, 0);
      checkOutput("t5ReqLow", bus.mem_req, 0);
      step; step;
      checkOutput("t5NoDone", doneCount - doneBase, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
